spi_arbiter: RTL and testbench
==============================

# spi_arbiter

Round-robin arbiter and transaction sequencer that shares one 12-bit SPI loopback datapath (`top`: `newd`/`din` in, `dout`/`done` out) between `NREQ` requesters. It holds each requester's word, drives the `newd`/`din` launch handshake for a programmable hold time, and waits for the `done` rising edge. It then returns `dout` with a one-cycle acknowledge, or an error pulse on timeout. It sits directly in front of `top`, replacing the directed stimulus driver.

## Interface

- `NREQ`, 4, number of requesters (2..8)
- `DW`, 12, SPI word width; must match `top`
- `NEWD_HOLD`, 20, clk cycles `newd` stays high; ≥ one SPI sync-clock period
- `GAP_CYCLES`, 20, idle clk cycles between transactions
- `TIMEOUT`, 1024, clk cycles in WAIT before abort
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req`  in  NREQ  level request per requester; held until its `ack`
- `req_data`  in  NREQ×DW  packed word per requester; requester i uses bits [i*DW +: DW]
- `gnt`  out  NREQ  one-hot grant; high from ISSUE through RESP
- `ack`  out  NREQ  one-hot, one-cycle completion pulse
- `rsp_valid`  out  1  one-cycle pulse, coincident with `ack`
- `rsp_data`  out  DW  returned word; valid with `rsp_valid`
- `rsp_err`  out  1  timeout flag; valid with `rsp_valid`
- `busy`  out  1  high in any state other than IDLE
- `newd`  out  1  to `top.newd`
- `din`  out  DW  to `top.din`; stable ISSUE through WAIT
- `done`  in  1  from `top.done`
- `dout`  in  DW  from `top.dout`

## Operation

- States: IDLE, ISSUE, WAIT, RESP, GAP.
- **IDLE:**
  - If `req` is nonzero, pick the winner: scan from `ptr` upward, wrapping to 0.
  - Register `gnt`, latch the winner's word into `din`, set `ptr` = (winner+1) mod NREQ, go to ISSUE.
- **ISSUE:**
  - `newd`=1 for exactly NEWD_HOLD cycles, then WAIT.
  - A `done` rising edge seen during ISSUE is latched into a pending flag.
- **WAIT:**
  - On a `done` rising edge (`done`=1 and registered `done_q`=0), or with the pending flag set: capture `dout` into `rsp_data`, go to RESP.
  - When the timeout counter reaches TIMEOUT: `rsp_data`=0, `rsp_err`=1, go to RESP.
- **RESP:** one cycle. `rsp_valid`=1, `ack`=`gnt`, then GAP.
- **GAP:** `gnt`=0 for GAP_CYCLES cycles, then IDLE.
- Requests seen in IDLE are not stored. A `req` that drops after grant does not abort the transaction. Requests that arrive during a transaction wait for the next IDLE.
- `req` must stay high until its `ack`. Because `gnt` and `ack` are registered, a requester deasserts `req` in the cycle after `ack`. The arbiter reaches IDLE only after GAP, so it never regrants a stale request.
- Counters are sized `$clog2(max(NEWD_HOLD,GAP_CYCLES,TIMEOUT)+1)` and saturate; they never wrap.
- `done_q` updates every cycle in all states, so a level-high `done` left over from the previous transaction is not counted as a new edge.

## Timing

- **Reset** (synchronous, any state including mid-transaction): next edge gives
  - state=IDLE, `ptr`=0, `done_q`=0, pending=0
  - `gnt`/`ack`/`rsp_valid`/`rsp_err`/`newd`/`busy`=0, `din`/`rsp_data`=0
  - `top` must be reset in the same cycle, from the same `rst`.
- **Launch:** `req` sampled at edge N → `gnt` and `newd` high after edge N+1. `newd` falls after edge N+1+NEWD_HOLD.
- **Response:** `done` rising edge sampled at edge M → `rsp_valid`/`ack`/`rsp_data` valid after edge M+1, for exactly one cycle.
- **Spacing:** earliest next grant comes GAP_CYCLES+1 cycles after `rsp_valid`.
- **Timeout:** `rsp_valid`=1 with `rsp_err`=1 exactly TIMEOUT cycles after WAIT entry.
- **Simultaneous events:** if a `done` edge and timeout expiry land in the same cycle, `done` wins (`rsp_err`=0).

## Structure

- **Package `spi_arb_pkg`:** state enum `arb_state_t` (IDLE, ISSUE, WAIT, RESP, GAP) and localparam `SPI_DW`=12.
- **Sub-module `spi_rr_pick`:** purely combinational. Takes `req` and `ptr`; returns one-hot `sel`, index `idx` and `any`. All state lives in `spi_arbiter`.

## Test plan

- **Single request:** `req[1]`=1, word 0x2A5, loopback `top` → `newd` high 20 cycles, then `ack[1]` pulse, `rsp_data`=0x2A5, `rsp_err`=0.
- **Full contention from reset:** all four `req` high together → grants in order 0,1,2,3, each separated by ≥GAP_CYCLES+1 idle cycles.
- **Fairness:** `req[0]` and `req[2]` re-asserted immediately after each `ack` → grants alternate 0,2,0,2 over 6 transactions.
- **Timeout:** `done` tied low, `req[3]` with 0x0FF → `rsp_valid`=1, `rsp_err`=1, `rsp_data`=0 exactly 1024 cycles after WAIT entry; `ptr` advances to 0.
- **Reset mid-WAIT:** `rst` for 1 cycle during WAIT → all outputs 0 next cycle. A pending `req[2]` is granted first after reset (`ptr`=0, scan finds 2).
- **Random soak:** 7 random words in 1..1000 from random requesters through `top` → every `rsp_data` equals its launched `din`; no ack is lost or duplicated.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared types for the SPI round-robin arbiter.
// Holds the sequencer state enum and the SPI word width.
package spi_arb_pkg;

  localparam int SPI_DW = 12;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    GAP
  } arb_state_t;

endpackage

// File: rtl/spi_rr_pick.sv
// spi_rr_pick: combinational round-robin picker, scans req from ptr up.
// In: req_i, ptr_i. Out: one-hot sel_o, index idx_o, any_o.
module spi_rr_pick
  import spi_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] sel_o,
  output logic [PW-1:0]   idx_o,
  output logic            any_o
);

  always_comb begin
    sel_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (int'(ptr_i) + k) % NREQ;
      if (!any_o && req_i[j]) begin
        sel_o[j] = 1'b1;
        idx_o    = j[PW-1:0];
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin sequencer sharing one SPI loopback (top).
// In: clk, rst, req, req_data, done, dout. Out: gnt, ack, rsp_*, busy, newd, din.
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int DW         = SPI_DW,
  parameter int NEWD_HOLD  = 20,
  parameter int GAP_CYCLES = 20,
  parameter int TIMEOUT    = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    ack,
  output logic               rsp_valid,
  output logic [DW-1:0]      rsp_data,
  output logic               rsp_err,
  output logic               busy,
  output logic               newd,
  output logic [DW-1:0]      din,
  input  logic               done,
  input  logic [DW-1:0]      dout
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int M1   = (NEWD_HOLD > GAP_CYCLES) ? NEWD_HOLD : GAP_CYCLES;
  localparam int MAXC = (M1 > TIMEOUT) ? M1 : TIMEOUT;
  localparam int CW   = $clog2(MAXC + 1);

  // Last-cycle marks: leaving on these makes each state last N cycles.
  localparam logic [CW-1:0] HOLD_END = CW'(NEWD_HOLD - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TO_END   = CW'(TIMEOUT - 1);

  arb_state_t        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [DW-1:0]     din_q, din_d;
  logic [DW-1:0]     rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              pend_q, pend_d;
  logic              done_q;
  logic              done_rise;

  logic [NREQ-1:0]   pick_sel;
  logic [PW-1:0]     pick_idx;
  logic              pick_any;

  spi_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .sel_o (pick_sel),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign done_rise = done & ~done_q;
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ptr_q      <= '0;
      gnt_q      <= '0;
      din_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      pend_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      din_q      <= din_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      pend_q     <= pend_d;
      done_q     <= done;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_inc;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    din_d      = din_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    pend_d     = pend_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pick_any) begin
          state_d   = ISSUE;
          gnt_d     = pick_sel;
          din_d     = req_data[int'(pick_idx)*DW +: DW];
          rsp_err_d = 1'b0;
          pend_d    = 1'b0;
          if (int'(pick_idx) == NREQ - 1) ptr_d = '0;
          else                            ptr_d = pick_idx + 1'b1;
        end
      end
      ISSUE: begin
        // A fast loopback can finish while newd is still held.
        if (done_rise) pend_d = 1'b1;
        if (cnt_q == HOLD_END) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        // done is checked first so it wins a tie with the timeout.
        if (done_rise || pend_q) begin
          state_d    = RESP;
          cnt_d      = '0;
          rsp_data_d = dout;
          rsp_err_d  = 1'b0;
          pend_d     = 1'b0;
        end else if (cnt_q == TO_END) begin
          state_d    = RESP;
          cnt_d      = '0;
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
        end
      end
      RESP: begin
        state_d = GAP;
        cnt_d   = '0;
        gnt_d   = '0;
      end
      GAP: begin
        if (cnt_q == GAP_END) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    newd      = (state_q == ISSUE);
    busy      = (state_q != IDLE);
    rsp_valid = (state_q == RESP);
    gnt       = gnt_q;
    din       = din_q;
    ack       = rsp_valid ? gnt_q : '0;
    rsp_data  = rsp_valid ? rsp_data_q : '0;
    rsp_err   = rsp_valid & rsp_err_q;
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: directed + random bench for spi_arbiter with a
// behavioural loopback stand-in for top and a round-robin reference.
module tb_spi_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 12;
  localparam int HOLD = 20;
  localparam int GAP  = 20;
  localparam int TO   = 1024;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]    gnt, ack;
  logic               rsp_valid, rsp_err, busy, newd;
  logic [DW-1:0]      rsp_data, din;
  logic               done = 1'b0;
  logic [DW-1:0]      dout = '0;

  spi_arbiter #(
    .NREQ       (NREQ),
    .DW         (DW),
    .NEWD_HOLD  (HOLD),
    .GAP_CYCLES (GAP),
    .TIMEOUT    (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .ack       (ack),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .newd      (newd),
    .din       (din),
    .done      (done),
    .dout      (dout)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int              lat   = 30;
  bit              stuck = 1'b0;
  int              cd    = 0;
  int              dhold = 0;
  logic [DW-1:0]   lw    = '0;
  logic            nd_prev = 1'b0;
  int              nd_run  = 0;
  logic [NREQ-1:0] g_prev  = '0;
  logic [NREQ-1:0] rearm   = '0;

  int g_cyc[$], g_vec[$], g_req[$];
  int r_cyc[$], r_ack[$], r_data[$], r_err[$];
  int n_len[$], n_fall[$], d_rise[$];
  int iss_req[$], iss_word[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr(input int set, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (p + k) % NREQ;
      if (set[j]) return j;
    end
    return -1;
  endfunction

  task automatic clear_logs();
    g_cyc.delete(); g_vec.delete(); g_req.delete();
    r_cyc.delete(); r_ack.delete(); r_data.delete(); r_err.delete();
    n_len.delete(); n_fall.delete(); d_rise.delete();
  endtask

  // One clock: advance, then model top and the requesters, then log.
  task automatic tick();
    logic [NREQ-1:0] rq_edge;
    rq_edge = req;
    @(posedge clk); #1;
    cyc++;
    if (rst) begin
      done = 1'b0; dout = '0; cd = 0; dhold = 0; nd_run = 0;
    end else begin
      if (dhold > 0) begin
        dhold--;
        if (dhold == 0) done = 1'b0;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          dout = lw; done = 1'b1; dhold = 3;
          d_rise.push_back(cyc);
        end
      end
      if (newd && !nd_prev && !stuck) begin
        cd = lat; lw = din;
      end
      if (newd) nd_run++;
      else if (nd_prev) begin
        n_len.push_back(nd_run); n_fall.push_back(cyc); nd_run = 0;
      end
      if (gnt != '0 && g_prev == '0) begin
        g_cyc.push_back(cyc);
        g_vec.push_back(int'(gnt));
        g_req.push_back(int'(rq_edge));
      end
      if (rsp_valid) begin
        r_cyc.push_back(cyc);
        r_ack.push_back(int'(ack));
        r_data.push_back(int'(rsp_data));
        r_err.push_back(int'(rsp_err));
        req = (req & ~ack) | (ack & rearm);
      end
    end
    nd_prev = newd;
    g_prev  = gnt;
  endtask

  task automatic wait_rsp(input string tag, input int n, input int budget);
    int b;
    b = 0;
    while (r_cyc.size() < n && b < budget) begin tick(); b++; end
    chk(tag, 32'(r_cyc.size()), 32'(n));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int b;
    b = 0;
    while (busy && b < budget) begin tick(); b++; end
    chk(tag, 32'(busy), 32'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; rearm = '0;
    tick(); tick();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},  32'(gnt), 0);
    chk({tag, "_ack"},  32'(ack), 0);
    chk({tag, "_rv"},   32'(rsp_valid), 0);
    chk({tag, "_err"},  32'(rsp_err), 0);
    chk({tag, "_newd"}, 32'(newd), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_din"},  32'(din), 0);
    chk({tag, "_rd"},   32'(rsp_data), 0);
  endtask

  initial begin
    int t0, mptr, e, issued, b, w, seen;
    int used[NREQ];

    // Reset state
    rst = 1'b1; tick(); tick();
    chk_all_zero("rst");
    rst = 1'b0; clear_logs();

    // Single request, loopback
    lat = 30;
    req_data[1*DW +: DW] = 12'h2A5;
    req = 4'b0010; t0 = cyc;
    wait_rsp("single_wait", 1, 500);
    chk("single_gnt", 32'(g_vec[0]), 32'h2);
    chk("single_gnt_lat", 32'(g_cyc[0] - t0), 1);
    chk("single_newd_len", 32'(n_len[0]), HOLD);
    chk("single_ack", 32'(r_ack[0]), 32'h2);
    chk("single_data", 32'(r_data[0]), 32'h2A5);
    chk("single_err", 32'(r_err[0]), 0);
    chk("single_rsp_lat", 32'(r_cyc[0] - d_rise[0]), 1);
    wait_idle("single_idle", 100);
    chk("single_one_pulse", 32'(r_cyc.size()), 1);

    // Full contention from reset
    do_reset();
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = DW'(12'h101 * (i + 1));
    req = 4'b1111;
    wait_rsp("cont_wait", 4, 2000);
    for (int k = 0; k < 4; k++) begin
      chk("cont_gnt", 32'(g_vec[k]), 32'(1 << k));
      chk("cont_ack", 32'(r_ack[k]), 32'(1 << k));
      chk("cont_data", 32'(r_data[k]), 32'(12'h101 * (k + 1)));
      if (k > 0)
        chk("cont_spacing", 32'((g_cyc[k] - r_cyc[k-1] - 1) >= GAP + 1), 1);
    end
    wait_idle("cont_idle", 100);

    // Fairness: 0 and 2 always requesting
    clear_logs();
    rearm = 4'b0101; req = 4'b0101;
    wait_rsp("fair_wait", 6, 3000);
    req = '0; rearm = '0;
    for (int k = 0; k < 6; k++)
      chk("fair_gnt", 32'(g_vec[k]), (k % 2 == 0) ? 32'h1 : 32'h4);
    wait_idle("fair_idle", 100);

    // done arrives while newd still held
    clear_logs();
    lat = 5;
    req_data[0 +: DW] = 12'h5C3; req = 4'b0001;
    wait_rsp("pend_wait", 1, 500);
    chk("pend_done_in_issue", 32'(d_rise[0] < n_fall[0]), 1);
    chk("pend_data", 32'(r_data[0]), 32'h5C3);
    chk("pend_lat", 32'(r_cyc[0] - n_fall[0]), 1);
    wait_idle("pend_idle", 100);

    // Timeout on requester 3
    clear_logs();
    stuck = 1'b1;
    req_data[3*DW +: DW] = 12'h0FF; req = 4'b1000;
    wait_rsp("to_wait", 1, 1500);
    chk("to_err", 32'(r_err[0]), 1);
    chk("to_data", 32'(r_data[0]), 0);
    chk("to_ack", 32'(r_ack[0]), 32'h8);
    chk("to_lat", 32'(r_cyc[0] - n_fall[0]), TO);
    wait_idle("to_idle", 100);
    stuck = 1'b0;

    // Pointer moved past 3: requester 0 wins over 3
    clear_logs();
    lat = 30;
    req_data[0 +: DW] = 12'h0A0; req_data[3*DW +: DW] = 12'h0B0;
    req = 4'b1001;
    wait_rsp("ptr_wait", 2, 1000);
    chk("ptr_first", 32'(g_vec[0]), 32'h1);
    chk("ptr_second", 32'(g_vec[1]), 32'h8);
    chk("ptr_data", 32'(r_data[1]), 32'h0B0);
    wait_idle("ptr_idle", 100);

    // done edge on the final WAIT cycle beats the timeout
    clear_logs();
    lat = HOLD + TO - 1;
    req_data[0 +: DW] = 12'h777; req = 4'b0001;
    wait_rsp("tie_wait", 1, 1500);
    chk("tie_err", 32'(r_err[0]), 0);
    chk("tie_data", 32'(r_data[0]), 32'h777);
    chk("tie_lat", 32'(r_cyc[0] - n_fall[0]), TO);
    wait_idle("tie_idle", 100);

    // Reset during WAIT, then pending requester 2 is served
    clear_logs();
    lat = 30; stuck = 1'b1;
    req_data[0 +: DW] = 12'h321; req = 4'b0001;
    b = 0;
    while (n_fall.size() < 1 && b < 200) begin tick(); b++; end
    chk("rstw_in_wait", 32'(n_fall.size()), 1);
    for (int k = 0; k < 10; k++) tick();
    req_data[2*DW +: DW] = 12'h456; req = 4'b0101;
    tick();
    rst = 1'b1; req = 4'b0100;
    tick();
    chk_all_zero("rstw");
    rst = 1'b0; stuck = 1'b0; clear_logs();
    wait_rsp("rstw_wait", 1, 500);
    chk("rstw_gnt", 32'(g_vec[0]), 32'h4);
    chk("rstw_data", 32'(r_data[0]), 32'h456);
    wait_idle("rstw_idle", 100);

    // Random soak against the round-robin reference
    do_reset();
    iss_req.delete(); iss_word.delete();
    issued = 0; b = 0;
    while ((issued < 7 || r_cyc.size() < 7) && b < 20000) begin
      lat = $urandom_range(3, 60);
      if (issued < 7 && $urandom_range(0, 15) == 0) begin
        e = $urandom_range(0, NREQ - 1);
        if (!req[e]) begin
          w = $urandom_range(1, 1000);
          req_data[e*DW +: DW] = w[DW-1:0];
          req[e] = 1'b1;
          iss_req.push_back(e); iss_word.push_back(w);
          issued++;
        end
      end
      tick(); b++;
    end
    wait_idle("soak_idle", 200);
    chk("soak_rsp_count", 32'(r_cyc.size()), 7);
    chk("soak_gnt_count", 32'(g_vec.size()), 7);
    mptr = 0;
    for (int i = 0; i < NREQ; i++) used[i] = 0;
    for (int k = 0; k < g_vec.size() && k < r_cyc.size(); k++) begin
      e = rr(g_req[k], mptr);
      chk("soak_winner", 32'(g_vec[k]), 32'(1 << e));
      chk("soak_ack", 32'(r_ack[k]), 32'(1 << e));
      mptr = (e + 1) % NREQ;
      w = -1; seen = 0;
      for (int i = 0; i < iss_req.size(); i++)
        if (iss_req[i] == e) begin
          if (seen == used[e]) w = iss_word[i];
          seen++;
        end
      used[e]++;
      chk("soak_data", 32'(r_data[k]), 32'(w));
      chk("soak_err", 32'(r_err[k]), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
